// File: rtl/mux_pkg.sv
// Shared defaults and select-width helper for the sequential channel mux.
package mux_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 2;

  // A one-bit select is kept even for degenerate channel counts so ports never collapse to zero width.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Auto-scan channel counter: load, increment, wrap from N-1 to 0, otherwise hold.
module scan_counter
  import mux_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int SW = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [SW-1:0] load_val_i,
  input  logic          inc_i,
  output logic [SW-1:0] cnt_o
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [SW-1:0] cnt_q, cnt_d, base;

  // A load samples the loaded channel this cycle, so the counter moves one past it.
  always_comb begin
    base  = load_i ? load_val_i : cnt_q;
    cnt_d = cnt_q;
    if (load_i || inc_i) begin
      cnt_d = (base == LAST) ? '0 : base + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_mux.sv
// Registered N-channel mux with manual select or auto-scan; one-cycle latency, valid pulses per sample.
module seq_mux
  import mux_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int W  = DEF_W,
  localparam int SW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in,
  input  logic [SW-1:0]   s,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   sel_q,
  output logic            valid
);

  localparam logic [SW:0] N_EXT = (SW + 1)'(N);

  logic          mode_q, mode_d;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] sel_d, idx, s_clip, cnt;
  logic          valid_q, valid_d;
  logic          entry, scan_inc;

  // Entry into scan mode seeds from s; a select past the last channel seeds channel 0.
  always_comb begin
    s_clip   = ({1'b0, s} < N_EXT) ? s : '0;
    entry    = en && mode && !mode_q;
    scan_inc = en && mode && mode_q;
    if (!mode) begin
      idx = s;
    end else if (entry) begin
      idx = s_clip;
    end else begin
      idx = cnt;
    end
  end

  scan_counter #(.N(N)) u_scan_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (entry),
    .load_val_i (s_clip),
    .inc_i      (scan_inc),
    .cnt_o      (cnt)
  );

  always_comb begin
    y_d     = y_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    mode_d  = mode_q;
    if (en) begin
      y_d     = ({1'b0, idx} < N_EXT) ? in[idx*W +: W] : '0;
      sel_d   = idx;
      valid_d = 1'b1;
      mode_d  = mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_seq_mux.sv
// Directed and model-checked bench for seq_mux across four parameter sets.
module tb_seq_mux;

  logic clk, rst, en, mode;

  logic [7:0]   in_a;  logic [1:0]  s_a;  logic [1:0]  y_a;  logic [1:0] sel_a;  logic v_a;
  logic [5:0]   in_b;  logic [1:0]  s_b;  logic [1:0]  y_b;  logic [1:0] sel_b;  logic v_b;
  logic [1:0]   in_c;  logic [0:0]  s_c;  logic [0:0]  y_c;  logic [0:0] sel_c;  logic v_c;
  logic [511:0] in_d;  logic [3:0]  s_d;  logic [31:0] y_d;  logic [3:0] sel_d;  logic v_d;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mux #(.N(4),  .W(2))  dut_a (.clk(clk), .rst(rst), .in(in_a), .s(s_a), .mode(mode), .en(en),
                                   .y(y_a), .sel_q(sel_a), .valid(v_a));
  seq_mux #(.N(3),  .W(2))  dut_b (.clk(clk), .rst(rst), .in(in_b), .s(s_b), .mode(mode), .en(en),
                                   .y(y_b), .sel_q(sel_b), .valid(v_b));
  seq_mux #(.N(2),  .W(1))  dut_c (.clk(clk), .rst(rst), .in(in_c), .s(s_c), .mode(mode), .en(en),
                                   .y(y_c), .sel_q(sel_c), .valid(v_c));
  seq_mux #(.N(16), .W(32)) dut_d (.clk(clk), .rst(rst), .in(in_d), .s(s_d), .mode(mode), .en(en),
                                   .y(y_d), .sel_q(sel_d), .valid(v_d));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour with integer arithmetic; state passed in and out per call.
  task automatic model(input int n, input int w, input int sv, input bit md, input bit e,
                       input logic [511:0] inv, inout int cnt, inout bit mh,
                       inout int sel, inout bit vld, inout logic [63:0] yv);
    int idx;
    logic [63:0] mask;
    if (e) begin
      if (md) begin
        if (!mh) cnt = (sv < n) ? sv : 0;
        idx = cnt;
        cnt = (cnt + 1) % n;
      end else begin
        idx = sv;
      end
      mask = (64'd1 << w) - 64'd1;
      sel  = idx;
      yv   = (idx < n) ? (64'(inv >> (idx * w)) & mask) : 64'd0;
      vld  = 1'b1;
      mh   = md;
    end else begin
      vld = 1'b0;
    end
  endtask

  initial begin
    int exp_scan[6];
    int c_cnt, c_sel, d_cnt, d_sel;
    bit c_mh, c_v, d_mh, d_v;
    logic [63:0] c_y, d_y;

    clk = 0; rst = 1; en = 0; mode = 0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    s_a = '0; s_b = '0; s_c = '0; s_d = '0;

    // Reset values with no clock edge yet, then held across an enabled edge.
    #2;
    check("rst_y",     64'(y_a),   64'd0);
    check("rst_sel",   64'(sel_a), 64'd0);
    check("rst_valid", 64'(v_a),   64'd0);
    in_a = 8'b11_10_01_00; s_a = 2'd3; en = 1;
    step();
    check("rst_hold_y",     64'(y_a), 64'd0);
    check("rst_hold_valid", 64'(v_a), 64'd0);
    #2 rst = 0;

    // Manual sweep.
    for (int i = 0; i < 4; i++) begin
      s_a = 2'(i);
      step();
      check("man_y",     64'(y_a),   64'(i));
      check("man_sel",   64'(sel_a), 64'(i));
      check("man_valid", 64'(v_a),   64'd1);
    end

    // Scan entry from s=2.
    exp_scan = '{2, 3, 0, 1, 2, 3};
    mode = 1; s_a = 2'd2;
    for (int i = 0; i < 6; i++) begin
      step();
      check("scan_sel",   64'(sel_a), 64'(exp_scan[i]));
      check("scan_y",     64'(y_a),   64'(exp_scan[i]));
      check("scan_valid", 64'(v_a),   64'd1);
    end

    // Enable gating in scan.
    step();
    check("en1_sel", 64'(sel_a), 64'd0); check("en1_valid", 64'(v_a), 64'd1);
    en = 0; step();
    check("en0_sel", 64'(sel_a), 64'd0); check("en0_valid", 64'(v_a), 64'd0);
    check("en0_y",   64'(y_a),   64'd0);
    en = 1; step();
    check("en2_sel", 64'(sel_a), 64'd1); check("en2_valid", 64'(v_a), 64'd1);

    // Mode toggle while disabled is ignored: scan continues rather than reloading from s.
    en = 0; mode = 0; step();
    check("tog_valid", 64'(v_a), 64'd0); check("tog_sel", 64'(sel_a), 64'd1);
    mode = 1; en = 1; s_a = 2'd3; step();
    check("tog_cont_sel", 64'(sel_a), 64'd2);

    // Exit then re-entry.
    mode = 0; s_a = 2'd1; step();
    check("exit_sel", 64'(sel_a), 64'd1); check("exit_y", 64'(y_a), 64'd1);
    mode = 1; s_a = 2'd0; step();
    check("reentry_sel", 64'(sel_a), 64'd0);

    // N=3: out-of-range manual select, then scan entry with s=3 starts at 0.
    in_b = {2'b01, 2'b10, 2'b11};
    mode = 0; s_b = 2'd3; step();
    check("n3_oor_y",   64'(y_b),   64'd0);
    check("n3_oor_sel", 64'(sel_b), 64'd3);
    check("n3_oor_v",   64'(v_b),   64'd1);
    mode = 1; step();
    check("n3_ent_sel", 64'(sel_b), 64'd0); check("n3_ent_y", 64'(y_b), 64'd3);
    step();
    check("n3_s1_sel",  64'(sel_b), 64'd1); check("n3_s1_y",  64'(y_b), 64'd2);
    step();
    check("n3_s2_sel",  64'(sel_b), 64'd2); check("n3_s2_y",  64'(y_b), 64'd1);
    step();
    check("n3_wrap_sel", 64'(sel_b), 64'd0);

    // Asynchronous reset mid-scan, then entry rule reapplies.
    mode = 0; s_a = 2'd3; step();
    mode = 1; s_a = 2'd1; step();
    step();
    check("pre_rst_sel", 64'(sel_a), 64'd2);
    #3 rst = 1;
    #1;
    check("arst_y",     64'(y_a),   64'd0);
    check("arst_sel",   64'(sel_a), 64'd0);
    check("arst_valid", 64'(v_a),   64'd0);
    #1 rst = 0;
    s_a = 2'd2; step();
    check("post_rst_sel", 64'(sel_a), 64'd2); check("post_rst_y", 64'(y_a), 64'd2);
    step();
    check("post_rst_sel2", 64'(sel_a), 64'd3);

    // Random sweep on the extreme parameter sets against the model.
    #2 rst = 1;
    #2 rst = 0;
    c_cnt = 0; c_sel = 0; c_mh = 0; c_v = 0; c_y = '0;
    d_cnt = 0; d_sel = 0; d_mh = 0; d_v = 0; d_y = '0;
    for (int k = 0; k < 300; k++) begin
      en   = ($urandom_range(0, 3) != 0);
      mode = ($urandom_range(0, 2) != 0);
      s_c  = 1'($urandom_range(0, 1));
      s_d  = 4'($urandom_range(0, 15));
      in_c = 2'($urandom);
      for (int j = 0; j < 16; j++) in_d[j*32 +: 32] = $urandom;
      model(2,  1,  int'(s_c), mode, en, 512'(in_c), c_cnt, c_mh, c_sel, c_v, c_y);
      model(16, 32, int'(s_d), mode, en, in_d,       d_cnt, d_mh, d_sel, d_v, d_y);
      step();
      check("c_y",   64'(y_c),   c_y);
      check("c_sel", 64'(sel_c), 64'(c_sel));
      check("c_v",   64'(v_c),   64'(c_v));
      check("d_y",   64'(y_d),   d_y);
      check("d_sel", 64'(sel_d), 64'(d_sel));
      check("d_v",   64'(v_d),   64'(d_v));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
